// File: rtl/bit_4_divider.sv
// Sequential 4-bit unsigned restoring divider: one quotient bit per clock,
// start/done handshake, registered quotient/remainder held between operations.
module bit_4_divider (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [3:0] divident,
  input  logic [3:0] divisor,
  output logic [3:0] q,
  output logic [3:0] r,
  output logic       busy,
  output logic       done,
  output logic       div_by_zero
);

  typedef enum logic {IDLE, RUN} state_t;

  state_t     state;
  logic [3:0] rem;
  logic [3:0] shreg;
  logic [3:0] dvs;
  logic [1:0] cnt;
  logic [4:0] step;
  logic [3:0] next_sh;

  // One restoring step: returns {quotient bit, new partial remainder}.
  // The 5-bit trial value can reach 29, but once the subtraction happens the
  // difference is below the divisor, so a 4-bit wrapping subtract is exact.
  function automatic logic [4:0] div_step(input logic [3:0] rem_in,
                                          input logic       bit_in,
                                          input logic [3:0] d);
    logic [4:0] trial;
    logic       ge;
    logic [3:0] diff;
    trial = {rem_in, bit_in};
    ge    = (trial >= {1'b0, d});
    diff  = trial[3:0] - d;
    return ge ? {1'b1, diff} : {1'b0, trial[3:0]};
  endfunction

  always_comb begin
    step    = div_step(rem, shreg[3], dvs);
    next_sh = {shreg[2:0], step[4]};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      rem         <= 4'd0;
      shreg       <= 4'd0;
      dvs         <= 4'd0;
      cnt         <= 2'd0;
      q           <= 4'd0;
      r           <= 4'd0;
      busy        <= 1'b0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            dvs   <= divisor;
            shreg <= divident;
            rem   <= 4'd0;
            cnt   <= 2'd0;
            busy  <= 1'b1;
            state <= RUN;
          end
        end
        RUN: begin
          rem   <= step[3:0];
          shreg <= next_sh;
          cnt   <= cnt + 2'd1;
          // Divisor 0 always subtracts nothing: q=F, r=dividend fall out naturally.
          if (cnt == 2'd3) begin
            q           <= next_sh;
            r           <= step[3:0];
            div_by_zero <= (dvs == 4'd0);
            done        <= 1'b1;
            busy        <= 1'b0;
            state       <= IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bit_4_divider.sv
// Scoreboard bench for bit_4_divider: expected results queued at accept,
// popped and compared when done pulses.
module tb_bit_4_divider;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [3:0] divident;
  logic [3:0] divisor;
  logic [3:0] q;
  logic [3:0] r;
  logic       busy;
  logic       done;
  logic       div_by_zero;

  bit_4_divider dut (
    .clk(clk), .rst_n(rst_n), .start(start), .divident(divident), .divisor(divisor),
    .q(q), .r(r), .busy(busy), .done(done), .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] q;
    logic [3:0] r;
    logic       dbz;
    int         acc;
  } exp_t;

  exp_t       sb[$];
  int         checks = 0;
  int         failures = 0;
  int         cyc = 0;
  logic [3:0] last_q = 4'd0;
  logic [3:0] last_r = 4'd0;
  logic       last_dbz = 1'b0;

  always @(posedge clk) cyc++;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] expv);
    checks++;
    if (got !== expv) begin
      failures++;
      $display("FAIL %s got=%0d expected=%0d (t=%0t)", tag, got, expv, $time);
    end
  endtask

  // Drive a request; the next rising edge accepts it (DUT must be idle there).
  task automatic start_op(input logic [3:0] a, input logic [3:0] b);
    exp_t e;
    start    = 1'b1;
    divident = a;
    divisor  = b;
    @(posedge clk);
    #1;
    e.q   = (b == 4'd0) ? 4'hF : 4'(a / b);
    e.r   = (b == 4'd0) ? a    : 4'(a % b);
    e.dbz = (b == 4'd0);
    e.acc = cyc;
    sb.push_back(e);
    chk("busy_after_accept", busy, 1);
    start = 1'b0;
  endtask

  task automatic wait_done();
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (done) return;
    end
    chk("done_timeout", 0, 1);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      chk("done_in_reset", done, 0);
      sb.delete();
      last_q   = 4'd0;
      last_r   = 4'd0;
      last_dbz = 1'b0;
    end else if (done) begin
      if (sb.size() == 0) begin
        chk("spurious_done", 1, 0);
      end else begin
        e = sb.pop_front();
        chk("q", q, e.q);
        chk("r", r, e.r);
        chk("div_by_zero", div_by_zero, e.dbz);
        chk("latency", cyc - e.acc, 4);
        chk("busy_at_done", busy, 0);
        last_q   = e.q;
        last_r   = e.r;
        last_dbz = e.dbz;
      end
    end else begin
      chk("hold_q", q, last_q);
      chk("hold_r", r, last_r);
      chk("hold_dbz", div_by_zero, last_dbz);
    end
  end

  initial begin
    rst_n    = 1'b0;
    start    = 1'b0;
    divident = 4'd0;
    divisor  = 4'd0;
    repeat (3) @(negedge clk);
    chk("reset_q", q, 0);
    chk("reset_r", r, 0);
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_dbz", div_by_zero, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // 13/3, then back-to-back 7/9, 15/1, 9/0 each started in the done cycle
    start_op(4'd13, 4'd3);
    wait_done();
    start_op(4'd7, 4'd9);
    wait_done();
    start_op(4'd15, 4'd1);
    wait_done();
    start_op(4'd9, 4'd0);
    wait_done();

    // 12/5 with start pulses and operand changes while busy
    @(negedge clk);
    start_op(4'd12, 4'd5);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      start    = 1'b1;
      divident = 4'($urandom_range(15));
      divisor  = 4'($urandom_range(15));
    end
    @(negedge clk);
    start = 1'b0;
    wait_done();
    repeat (8) @(negedge clk);

    // Reset mid-operation discards the in-flight result
    start_op(4'd11, 4'd2);
    @(negedge clk);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midreset_q", q, 0);
    chk("midreset_r", r, 0);
    chk("midreset_busy", busy, 0);
    chk("midreset_done", done, 0);
    chk("midreset_dbz", div_by_zero, 0);
    repeat (6) @(negedge clk);
    #2 rst_n = 1'b1;
    repeat (6) @(negedge clk);

    // Exhaustive operand sweep
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        start_op(4'(a), 4'(b));
        wait_done();
      end
    end

    repeat (4) @(negedge clk);
    chk("queue_empty", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
